// File: rtl/pmem_burst_responder.sv
// pmem_burst_responder: line-oriented memory model answering reads/writes with 4-beat 64-bit bursts after LATENCY idle cycles
//   clk, rst          : clock, synchronous active-high reset
//   pmem_read/write   : line request, held by the initiator until the last beat
//   pmem_address      : byte address, line index taken from bits [4+log2(DEPTH_LINES):5]
//   pmem_wdata        : write beat data, one beat per pmem_resp cycle
//   pmem_rdata        : read beat data, zero whenever no read beat is being returned
//   pmem_resp         : beat strobe, four consecutive cycles per transaction
//   protocol_err      : sticky flag for conflicting or unstable requests
module pmem_burst_responder #(
  parameter int LATENCY     = 4,
  parameter int DEPTH_LINES = 512
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pmem_read,
  input  logic        pmem_write,
  input  logic [31:0] pmem_address,
  input  logic [63:0] pmem_wdata,
  output logic [63:0] pmem_rdata,
  output logic        pmem_resp,
  output logic        protocol_err
);
  localparam int IW = $clog2(DEPTH_LINES);
  typedef enum logic [1:0] {IDLE, WAIT, BURST, DONE} state_t;
  state_t          state_q, state_d;
  logic [7:0]      cnt_q, cnt_d;
  logic [1:0]      beat_q, beat_d;
  logic            op_q, op_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic            err_q, err_d;
  logic            busy, hold_ok, we;
  logic            unused_addr;
  // Stored as 64-bit beats: word address is {line index, beat}
  logic [63:0]     mem [DEPTH_LINES*4] = '{default: '0};
  assign unused_addr  = ^{pmem_address[31:5+IW], pmem_address[4:0]};
  assign busy         = state_q == WAIT || state_q == BURST;
  // The initiator must keep exactly the latched op asserted until the last beat
  assign hold_ok      = op_q ? (pmem_write && !pmem_read) : (pmem_read && !pmem_write);
  // Reset wins over the write of the beat ending on the same edge
  assign we           = state_q == BURST && op_q && !rst;
  assign pmem_resp    = state_q == BURST;
  assign pmem_rdata   = (state_q == BURST && !op_q) ? mem[{idx_q, beat_q}] : '0;
  assign protocol_err = err_q;
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    beat_d  = beat_q;
    op_d    = op_q;
    idx_d   = idx_q;
    err_d   = err_q || (busy && !hold_ok) || (state_q == IDLE && pmem_read && pmem_write);
    unique case (state_q)
      IDLE: if (pmem_read ^ pmem_write) begin
        state_d = WAIT;
        op_d    = pmem_write;
        idx_d   = pmem_address[4+IW:5];
        cnt_d   = 8'(LATENCY - 1);
      end
      WAIT: begin
        cnt_d   = cnt_q == 8'd0 ? 8'd0 : cnt_q - 8'd1;
        state_d = cnt_q == 8'd0 ? BURST : WAIT;
        beat_d  = 2'd0;
      end
      BURST: begin
        beat_d  = beat_q + 2'd1;
        state_d = beat_q == 2'd3 ? DONE : BURST;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      beat_q  <= '0;
      op_q    <= 1'b0;
      idx_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      beat_q  <= beat_d;
      op_q    <= op_d;
      idx_q   <= idx_d;
      err_q   <= err_d;
    end
  end
  always_ff @(posedge clk) begin
    if (we) mem[{idx_q, beat_q}] <= pmem_wdata;
  end
endmodule

// File: tb/tb_pmem_burst_responder.sv
// tb_pmem_burst_responder: directed checks of burst timing, data, wrap, protocol errors and reset behaviour
module tb_pmem_burst_responder;
  localparam int LAT = 4;
  localparam logic [255:0] LA = {64'hA3A3_0003_0000_A3A3, 64'hA2A2_0002_0000_A2A2, 64'hA1A1_0001_0000_A1A1, 64'hA0A0_0000_0000_A0A0};
  localparam logic [255:0] LB = {64'hB3B3_3333_DEAD_0003, 64'hB2B2_2222_DEAD_0002, 64'hB1B1_1111_DEAD_0001, 64'hB0B0_0000_DEAD_0000};
  localparam logic [255:0] LC = {64'hC3C3_C3C3_C3C3_C3C3, 64'hC2C2_C2C2_C2C2_C2C2, 64'hC1C1_C1C1_C1C1_C1C1, 64'hC0C0_C0C0_C0C0_C0C0};
  logic        clk = 1'b0;
  logic        rst;
  logic        pmem_read;
  logic        pmem_write;
  logic [31:0] pmem_address;
  logic [63:0] pmem_wdata;
  logic [63:0] pmem_rdata;
  logic        pmem_resp;
  logic        protocol_err;
  logic [255:0] r;
  int n_cmp = 0;
  int n_err = 0;
  pmem_burst_responder #(.LATENCY(LAT), .DEPTH_LINES(512)) dut (
    .clk(clk), .rst(rst), .pmem_read(pmem_read), .pmem_write(pmem_write),
    .pmem_address(pmem_address), .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata),
    .pmem_resp(pmem_resp), .protocol_err(protocol_err)
  );
  always #5 clk = ~clk;
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  // One transaction starting in the current IDLE cycle (cycle 0); returns in cycle LAT+6 (IDLE again).
  // drop: WAIT cycle in which the request is removed (0 = never); hold: keep request through DONE;
  // rst_beat: beat on which reset is pulsed (-1 = never), ending the transaction early.
  task automatic xact(input bit w, input logic [31:0] a, input logic [255:0] wl, output logic [255:0] rl,
                      input int drop, input bit hold, input int rst_beat);
    rl = '0;
    pmem_read = !w;
    pmem_write = w;
    pmem_address = a;
    pmem_wdata = wl[63:0];
    for (int c = 1; c <= LAT; c++) begin
      step;
      pmem_address = ~a;
      if (c == drop) begin
        pmem_read = 1'b0;
        pmem_write = 1'b0;
      end
      chk("wait_resp", 256'(pmem_resp), '0);
      chk("wait_rdata", 256'(pmem_rdata), '0);
    end
    for (int k = 0; k < 4; k++) begin
      step;
      chk("beat_resp", 256'(pmem_resp), 256'(1));
      if (w) chk("wr_rdata", 256'(pmem_rdata), '0);
      rl[64*k+:64] = pmem_rdata;
      pmem_wdata = wl[64*k+:64];
      if (k == rst_beat) begin
        rst = 1'b1;
        pmem_read = 1'b0;
        pmem_write = 1'b0;
        step;
        rst = 1'b0;
        chk("rst_resp", 256'(pmem_resp), '0);
        chk("rst_rdata", 256'(pmem_rdata), '0);
        chk("rst_err", 256'(protocol_err), '0);
        return;
      end
    end
    step;
    chk("done_resp", 256'(pmem_resp), '0);
    if (!hold) begin
      pmem_read = 1'b0;
      pmem_write = 1'b0;
    end
    step;
    chk("idle_resp", 256'(pmem_resp), '0);
  endtask
  initial begin
    rst = 1'b1;
    pmem_read = 1'b0;
    pmem_write = 1'b0;
    pmem_address = '0;
    pmem_wdata = '0;
    step;
    step;
    rst = 1'b0;
    chk("reset_resp", 256'(pmem_resp), '0);
    chk("reset_rdata", 256'(pmem_rdata), '0);
    chk("reset_err", 256'(protocol_err), '0);
    xact(1'b0, 32'h0000_0040, '0, r, 0, 1'b0, -1);
    chk("zero_init", r, '0);
    xact(1'b1, 32'h0000_0040, LA, r, 0, 1'b0, -1);
    xact(1'b0, 32'h0000_0040, '0, r, 0, 1'b1, -1);
    chk("read_a", r, LA);
    xact(1'b0, 32'h0000_0040, '0, r, 0, 1'b0, -1);
    chk("read_a_back_to_back", r, LA);
    xact(1'b1, 32'h0000_4020, LB, r, 0, 1'b0, -1);
    xact(1'b0, 32'h0000_0020, '0, r, 0, 1'b0, -1);
    chk("wrap_b", r, LB);
    xact(1'b0, 32'hFFFF_C05F, '0, r, 0, 1'b0, -1);
    chk("a_intact_high_bits", r, LA);
    chk("err_clean", 256'(protocol_err), '0);
    xact(1'b0, 32'h0000_0020, '0, r, 2, 1'b0, -1);
    chk("drop_data", r, LB);
    chk("drop_err", 256'(protocol_err), 256'(1));
    step;
    chk("drop_err_sticky", 256'(protocol_err), 256'(1));
    rst = 1'b1;
    step;
    rst = 1'b0;
    chk("err_cleared", 256'(protocol_err), '0);
    pmem_read = 1'b1;
    pmem_write = 1'b1;
    for (int i = 0; i < 12; i++) begin
      step;
      chk("both_resp", 256'(pmem_resp), '0);
      chk("both_err", 256'(protocol_err), 256'(1));
    end
    pmem_read = 1'b0;
    pmem_write = 1'b0;
    step;
    step;
    chk("both_err_sticky", 256'(protocol_err), 256'(1));
    rst = 1'b1;
    step;
    rst = 1'b0;
    chk("both_err_cleared", 256'(protocol_err), '0);
    xact(1'b1, 32'h0000_0040, LC, r, 0, 1'b0, 2);
    step;
    xact(1'b0, 32'h0000_0040, '0, r, 0, 1'b0, -1);
    chk("rst_mid_write", r, {LA[255:128], LC[127:0]});
    chk("final_err", 256'(protocol_err), '0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
